gate_truth_classifier: RTL and testbench

- Sequential counterpart to the team's combinational two-input gate blocks: drives a/b stimulus into a gate-under-test and captures its response bit.
- Sweeps all four input combinations, assembles a 4-bit truth table and decodes which gate function is connected.
- Sits beside any gate instance as a built-in self-identification / self-check engine, with a start/busy/done handshake.

---
 rtl/gate_truth_classifier.sv | 229 ++++++++++++++++++++++
 tb/tb_gate_truth_classifier.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_truth_classifier.sv
// ---------------------------------------------------------------------------
// gate_truth_classifier
//
// Purpose: self-identification engine for a two-input gate. It drives the four
// a/b vectors 00, 01, 10, 11 into the gate-under-test, holding each for
// SETTLE_CYCLES cycles before capturing the response. It then builds a 4-bit
// truth table and decodes which gate function is connected.
//
// Parameters:
//   SETTLE_CYCLES  cycles each vector is held before sampling (1..15; 0 -> 1)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   sweep request, sampled only while idle
//   resp       in   response bit from the gate-under-test
//   drv_a      out  stimulus a (registered)
//   drv_b      out  stimulus b (registered)
//   busy       out  high from the cycle after start is accepted through DONE
//   done       out  one-cycle pulse when the results below update
//   truth_tbl  out  bit i = response captured for {drv_a,drv_b} = i
//   gate_code  out  0 NOT(a), 1 AND, 2 OR, 3 NAND, 4 NOR, 5 XOR, 6 XNOR,
//                   7 unknown
//   valid_gate out  high when gate_code is 0..6
//   unstable   out  (only with GATE_CLS_STABLE_EN) response changed inside a
//                   settle window during the last sweep
//
// Optional feature macro: GATE_CLS_STABLE_EN
// ---------------------------------------------------------------------------
module gate_truth_classifier #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       resp,
  output logic       drv_a,
  output logic       drv_b,
  output logic       busy,
  output logic       done,
  output logic [3:0] truth_tbl,
  output logic [2:0] gate_code,
  output logic       valid_gate
`ifdef GATE_CLS_STABLE_EN
  ,
  output logic       unstable
`endif
);

  localparam int unsigned S_EFF    = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
  localparam logic [3:0]  CNT_LAST = 4'(S_EFF - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Map a captured truth table onto a gate code; anything unrecognised is 7.
  function automatic logic [2:0] decode_gate(input logic [3:0] tbl);
    logic [2:0] code;
    case (tbl)
      4'b0011: code = 3'd0;
      4'b1000: code = 3'd1;
      4'b1110: code = 3'd2;
      4'b0111: code = 3'd3;
      4'b0001: code = 3'd4;
      4'b0110: code = 3'd5;
      4'b1001: code = 3'd6;
      default: code = 3'd7;
    endcase
    return code;
  endfunction

  logic [1:0] state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] scratch_q, scratch_d;
  logic [1:0] drv_q, drv_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [3:0] tbl_q, tbl_d;
  logic [2:0] code_q, code_d;
  logic       valid_q, valid_d;
`ifdef GATE_CLS_STABLE_EN
  logic       pre_q, pre_d;
  logic       flag_q, flag_d;
  logic       unstable_q, unstable_d;
`endif

  // Next-state logic for the sweep FSM and its datapath.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    scratch_d = scratch_q;
    drv_d     = drv_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    tbl_d     = tbl_q;
    code_d    = code_q;
    valid_d   = valid_q;
`ifdef GATE_CLS_STABLE_EN
    pre_d      = pre_q;
    flag_d     = flag_q;
    unstable_d = unstable_q;
`endif
    case (state_q)
      ST_IDLE: begin
        drv_d = 2'b00;
        if (start) begin
          scratch_d = 4'b0000;
          idx_d     = 2'd0;
          cnt_d     = 4'd0;
          busy_d    = 1'b1;
          state_d   = ST_SETTLE;
`ifdef GATE_CLS_STABLE_EN
          flag_d    = 1'b0;
`endif
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_SETTLE: begin
        drv_d = idx_q;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_SAMPLE;
`ifdef GATE_CLS_STABLE_EN
          pre_d   = resp;
`endif
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_SAMPLE: begin
        scratch_d[idx_q] = resp;
`ifdef GATE_CLS_STABLE_EN
        flag_d = flag_q | (resp ^ pre_q);
`endif
        if (idx_q == 2'd3) begin
          // Results are loaded on the edge into DONE so they are already
          // visible during the done pulse.
          state_d = ST_DONE;
          drv_d   = 2'b00;
          done_d  = 1'b1;
          tbl_d   = scratch_d;
          code_d  = decode_gate(scratch_d);
          valid_d = (decode_gate(scratch_d) != 3'd7);
`ifdef GATE_CLS_STABLE_EN
          unstable_d = flag_d;
          if (flag_d) begin
            code_d  = 3'd7;
            valid_d = 1'b0;
          end else begin
            code_d  = decode_gate(scratch_d);
          end
`endif
        end else begin
          idx_d   = idx_q + 2'd1;
          cnt_d   = 4'd0;
          drv_d   = idx_q + 2'd1;
          state_d = ST_SETTLE;
        end
      end
      ST_DONE: begin
        drv_d   = 2'b00;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        drv_d   = 2'b00;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= 2'd0;
      cnt_q     <= 4'd0;
      scratch_q <= 4'b0000;
      drv_q     <= 2'b00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tbl_q     <= 4'b0000;
      code_q    <= 3'd0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      scratch_q <= scratch_d;
      drv_q     <= drv_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tbl_q     <= tbl_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
    end
  end

`ifdef GATE_CLS_STABLE_EN
  // Stability-check registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q      <= 1'b0;
      flag_q     <= 1'b0;
      unstable_q <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      flag_q     <= flag_d;
      unstable_q <= unstable_d;
    end
  end

  assign unstable = unstable_q;
`endif

  assign drv_a      = drv_q[1];
  assign drv_b      = drv_q[0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign truth_tbl  = tbl_q;
  assign gate_code  = code_q;
  assign valid_gate = valid_q;

endmodule

// File: tb/tb_gate_truth_classifier.sv
// ---------------------------------------------------------------------------
// tb_gate_truth_classifier
//
// Bench for gate_truth_classifier (SETTLE_CYCLES = 2). A behavioural gate model
// answers the DUT's stimulus. The expected truth table is built from that
// model when each sweep starts and is queued. It is popped and compared when
// done is seen.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gate_truth_classifier;

  typedef struct packed {
    logic [3:0] tbl;
    logic [2:0] code;
    logic       valid;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       resp;
  logic       drv_a;
  logic       drv_b;
  logic       busy;
  logic       done;
  logic [3:0] truth_tbl;
  logic [2:0] gate_code;
  logic       valid_gate;
`ifdef GATE_CLS_STABLE_EN
  logic       unstable;
`endif

  int   total;
  int   bad;
  int   mode;
  logic tog;
  exp_t sb[$];

  gate_truth_classifier #(.SETTLE_CYCLES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .resp       (resp),
    .drv_a      (drv_a),
    .drv_b      (drv_b),
    .busy       (busy),
    .done       (done),
    .truth_tbl  (truth_tbl),
    .gate_code  (gate_code),
    .valid_gate (valid_gate)
`ifdef GATE_CLS_STABLE_EN
    ,
    .unstable   (unstable)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) tog <= ~tog;

  // Gate model: 0 AND, 1 XNOR, 2 NOT a, 3 tie0, 4 tie1, 5 OR, 6 XOR,
  // 7 XOR whose output toggles every cycle while {a,b}=01.
  function automatic logic gate_eval(input int m, input logic a, input logic b);
    case (m)
      0:       return a & b;
      1:       return ~(a ^ b);
      2:       return ~a;
      3:       return 1'b0;
      4:       return 1'b1;
      5:       return a | b;
      default: return a ^ b;
    endcase
  endfunction

  assign resp = gate_eval(mode, drv_a, drv_b) ^
                ((mode == 7 && {drv_a, drv_b} == 2'b01) ? tog : 1'b0);

  function automatic logic [3:0] model_tbl(input int m);
    logic [3:0] t;
    logic [1:0] v;
    for (int i = 0; i < 4; i++) begin
      v    = 2'(i);
      t[i] = gate_eval(m, v[1], v[0]);
    end
    return t;
  endfunction

  // Queue the expected result for the sweep about to start.
  task automatic push_exp(input int m, input logic [2:0] code, input logic valid);
    exp_t e;
    e.tbl   = model_tbl(m);
    e.code  = code;
    e.valid = valid;
    sb.push_back(e);
  endtask

  // Pulse start, then wait (bounded) for done; returns the latency in cycles.
  task automatic do_sweep(output int lat);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 0;
    tog   = 1'b0;
    #12;
    total++;
    if ({drv_a, drv_b, busy, done, truth_tbl, gate_code, valid_gate} !== 12'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=0",
               {drv_a, drv_b, busy, done, truth_tbl, gate_code, valid_gate});
    end
`ifdef GATE_CLS_STABLE_EN
    total++;
    if (unstable !== 1'b0) begin
      bad++;
      $display("FAIL reset_unstable got=%b want=0", unstable);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_and;
    exp_t e;
    int   c;
    mode = 0;
    push_exp(0, 3'd1, 1'b1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (c = 1; c <= 14; c++) begin
      total++;
      if (busy !== (c <= 13)) begin
        bad++;
        $display("FAIL and_busy cycle=%0d got=%b want=%b", c, busy, (c <= 13));
      end
      total++;
      if (done !== (c == 13)) begin
        bad++;
        $display("FAIL and_done cycle=%0d got=%b want=%b", c, done, (c == 13));
      end
      if (c == 13) begin
        e = sb.pop_front();
        total++;
        if ({truth_tbl, gate_code, valid_gate} !== {e.tbl, e.code, e.valid}) begin
          bad++;
          $display("FAIL and_result got=%b/%0d/%b want=%b/%0d/%b",
                   truth_tbl, gate_code, valid_gate, e.tbl, e.code, e.valid);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_xnor_not;
    exp_t e;
    int   lat;
    mode = 1;
    push_exp(1, 3'd6, 1'b1);
    do_sweep(lat);
    e = sb.pop_front();
    total++;
    if (lat != 13 || {truth_tbl, gate_code, valid_gate} !== {e.tbl, e.code, e.valid}) begin
      bad++;
      $display("FAIL xnor_result lat=%0d got=%b/%0d/%b want lat=13 %b/%0d/%b",
               lat, truth_tbl, gate_code, valid_gate, e.tbl, e.code, e.valid);
    end
    // Change the gate but do not start: results must hold.
    mode = 2;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if ({truth_tbl, gate_code, valid_gate} !== {4'b1001, 3'd6, 1'b1}) begin
      bad++;
      $display("FAIL xnor_hold got=%b/%0d/%b want 1001/6/1",
               truth_tbl, gate_code, valid_gate);
    end
    push_exp(2, 3'd0, 1'b1);
    do_sweep(lat);
    e = sb.pop_front();
    total++;
    if (lat != 13 || {truth_tbl, gate_code, valid_gate} !== {e.tbl, e.code, e.valid}) begin
      bad++;
      $display("FAIL not_result lat=%0d got=%b/%0d/%b want lat=13 %b/%0d/%b",
               lat, truth_tbl, gate_code, valid_gate, e.tbl, e.code, e.valid);
    end
  endtask

  task automatic test_const;
    exp_t e;
    int   lat;
    for (int m = 3; m <= 4; m++) begin
      @(posedge clk); #1;
      mode = m;
      push_exp(m, 3'd7, 1'b0);
      do_sweep(lat);
      e = sb.pop_front();
      total++;
      if (lat != 13 || {truth_tbl, gate_code, valid_gate} !== {e.tbl, e.code, e.valid}) begin
        bad++;
        $display("FAIL const_result mode=%0d lat=%0d got=%b/%0d/%b want %b/%0d/%b",
                 m, lat, truth_tbl, gate_code, valid_gate, e.tbl, e.code, e.valid);
      end
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   n_done;
    @(posedge clk); #1;
    mode = 0;
    push_exp(0, 3'd1, 1'b1);
    n_done = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 28; c++) begin
      start = (c == 4 || c == 9 || c == 14);
      if (c == 14) push_exp(0, 3'd1, 1'b1);
      if (done === 1'b1) begin
        n_done++;
        e = sb.pop_front();
        total++;
        if ((c != 13 && c != 27) || truth_tbl !== e.tbl || gate_code !== e.code) begin
          bad++;
          $display("FAIL b2b_done cycle=%0d got=%b/%0d want cycle 13 or 27 %b/%0d",
                   c, truth_tbl, gate_code, e.tbl, e.code);
        end
      end
      if (c == 14) begin
        total++;
        if (n_done != 1) begin
          bad++;
          $display("FAIL b2b_first_count got=%0d want=1", n_done);
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    total++;
    if (n_done != 2) begin
      bad++;
      $display("FAIL b2b_total_count got=%0d want=2", n_done);
    end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    int   lat;
    int   n_done;
    mode = 5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    total++;
    if ({drv_a, drv_b, busy, done, truth_tbl, gate_code, valid_gate} !== 12'd0) begin
      bad++;
      $display("FAIL midreset_outputs got=%b want=0",
               {drv_a, drv_b, busy, done, truth_tbl, gate_code, valid_gate});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_done = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done === 1'b1) n_done++;
    end
    total++;
    if (n_done != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midreset_idle dones=%0d busy=%b want 0/0", n_done, busy);
    end
    push_exp(5, 3'd2, 1'b1);
    do_sweep(lat);
    e = sb.pop_front();
    total++;
    if (lat != 13 || {truth_tbl, gate_code, valid_gate} !== {e.tbl, e.code, e.valid}) begin
      bad++;
      $display("FAIL or_result lat=%0d got=%b/%0d/%b want lat=13 %b/%0d/%b",
               lat, truth_tbl, gate_code, valid_gate, e.tbl, e.code, e.valid);
    end
  endtask

`ifdef GATE_CLS_STABLE_EN
  task automatic test_unstable;
    exp_t e;
    int   lat;
    @(posedge clk); #1;
    mode = 7;
    push_exp(6, 3'd7, 1'b0);
    do_sweep(lat);
    e = sb.pop_front();
    total++;
    if (lat != 13 || unstable !== 1'b1 || gate_code !== e.code || valid_gate !== e.valid) begin
      bad++;
      $display("FAIL unstable_flag lat=%0d unst=%b code=%0d valid=%b want 13/1/%0d/%b",
               lat, unstable, gate_code, valid_gate, e.code, e.valid);
    end
    @(posedge clk); #1;
    mode = 6;
    push_exp(6, 3'd5, 1'b1);
    do_sweep(lat);
    e = sb.pop_front();
    total++;
    if (unstable !== 1'b0 || {truth_tbl, gate_code, valid_gate} !== {e.tbl, e.code, e.valid}) begin
      bad++;
      $display("FAIL unstable_clear unst=%b got=%b/%0d/%b want 0 %b/%0d/%b",
               unstable, truth_tbl, gate_code, valid_gate, e.tbl, e.code, e.valid);
    end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset;
    test_and;
    test_xnor_not;
    test_const;
    test_back_to_back;
    test_reset_mid;
`ifdef GATE_CLS_STABLE_EN
    test_unstable;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
